// File: rtl/processor_nios2_qsys_0_oci_pkg.sv
// Shared OCI debug-path types and constants for the data-trace packer.
package processor_nios2_qsys_0_oci_pkg;

  localparam int DCT_SLOTS  = 15;
  localparam int DCT_SLOT_W = 2;
  localparam int DCT_BUF_W  = DCT_SLOTS * DCT_SLOT_W;
  localparam int DCT_CNT_W  = 4;

  // Word handed to the trace memory writer: count in the top bits.
  typedef struct packed {
    logic [DCT_CNT_W-1:0] count;
    logic [DCT_BUF_W-1:0] buffer;
  } dct_word_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } dct_out_state_t;

endpackage

// File: rtl/processor_nios2_qsys_0_oci_dct_outreg.sv
// Single-entry valid/ready output register for the DCT packer.
// A load may land in the same cycle the held word is taken.
module processor_nios2_qsys_0_oci_dct_outreg
  import processor_nios2_qsys_0_oci_pkg::*;
#(
  parameter int W = DCT_CNT_W + DCT_BUF_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         free_o
);

  dct_out_state_t state_q, state_d;
  logic [W-1:0]   data_q, data_d;

  // Next state: a load always wins; otherwise a taken word empties the slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = FULL;
      data_d  = data_i;
    end else if (state_q == FULL && out_ready_i) begin
      state_d = EMPTY;
    end
  end

  // State and data registers; a reset discards any pending word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign free_o      = (state_q == EMPTY) || out_ready_i;

endmodule

// File: rtl/processor_nios2_qsys_0_oci_dct_packer.sv
// Data-trace compression packer: shifts 2-bit codes into a 15-slot buffer
// and emits full or flushed buffers as {count, buffer} words.
// Optional drop-on-overflow mode: define PROCESSOR_OCI_DCT_OVERFLOW_EN.
module processor_nios2_qsys_0_oci_dct_packer
  import processor_nios2_qsys_0_oci_pkg::*;
#(
  parameter int SLOTS  = DCT_SLOTS,
  parameter int SLOT_W = DCT_SLOT_W,
  parameter int CNT_W  = DCT_CNT_W
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            code_valid,
  input  logic [SLOT_W-1:0]               code,
  output logic                            code_ready,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CNT_W+SLOTS*SLOT_W-1:0]   out_word,
  output logic [SLOTS*SLOT_W-1:0]         dct_buffer,
  output logic [CNT_W-1:0]                dct_count,
  output logic                            overflow
);

  localparam int BUF_W = SLOTS * SLOT_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

  logic [BUF_W-1:0] buf_q, buf_d, buf_app;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_app;
  logic             pend_q, pend_d;
  logic             free, cnt_full, flush_req, xfer, honoured;
  logic             acc_app, acc_new;

  assign cnt_full = (cnt_q == CNT_FULL);

`ifdef PROCESSOR_OCI_DCT_OVERFLOW_EN
  // Never backpressure: codes that cannot be placed are dropped. At a held
  // full buffer with the output free, the incoming code starts the next word.
  logic drop, ovf_q;
  assign code_ready = 1'b1;
  assign acc_app    = code_valid && !cnt_full && !pend_q;
  assign acc_new    = code_valid &&  cnt_full && !pend_q && free;
  assign drop       = code_valid && !acc_app && !acc_new;

  // Sticky drop flag; a drop in the same cycle as an honoured flush survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      ovf_q <= 1'b0;
    else if (drop)     ovf_q <= 1'b1;
    else if (honoured) ovf_q <= 1'b0;
  end
  assign overflow = ovf_q;
`else
  assign code_ready = !cnt_full && !pend_q;
  assign acc_app    = code_valid && code_ready;
  assign acc_new    = 1'b0;
  assign overflow   = 1'b0;
`endif

  // Append first, then decide whether the (possibly new) buffer leaves.
  always_comb begin
    buf_app   = buf_q;
    cnt_app   = cnt_q;
    if (acc_app) begin
      buf_app = {buf_q[BUF_W-SLOT_W-1:0], code};
      cnt_app = cnt_q + CNT_W'(1);
    end
    flush_req = flush || pend_q;
    xfer      = free && ((cnt_app == CNT_FULL) || (flush_req && cnt_app != '0));
    honoured  = xfer && flush_req;
    buf_d     = buf_app;
    cnt_d     = cnt_app;
    pend_d    = flush_req && (cnt_app != '0);
    if (xfer) begin
      pend_d = 1'b0;
      if (acc_new) begin
        buf_d = {{(BUF_W-SLOT_W){1'b0}}, code};
        cnt_d = CNT_W'(1);
      end else begin
        buf_d = '0;
        cnt_d = '0;
      end
    end
  end

  // Packing buffer, slot count and pending-flush registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  processor_nios2_qsys_0_oci_dct_outreg #(.W(CNT_W + BUF_W)) u_outreg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (xfer),
    .data_i      ({cnt_app, buf_app}),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_word),
    .free_o      (free)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;

endmodule

// File: tb/tb_processor_nios2_qsys_0_oci_dct_packer.sv
// Directed self-checking bench for the DCT packer.
module tb_processor_nios2_qsys_0_oci_dct_packer;
  import processor_nios2_qsys_0_oci_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        code_valid = 1'b0;
  logic [1:0]  code = 2'd0;
  logic        code_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [33:0] out_word;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  processor_nios2_qsys_0_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .overflow(overflow)
  );

  function automatic logic [33:0] w(input logic [3:0] c, input logic [29:0] b);
    dct_word_t t;
    t.count = c; t.buffer = b;
    return t;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL reset_code_ready got %b exp 1", code_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_word !== 34'h0) begin errors++; $display("FAIL reset_out_word got %h exp 0", out_word); end
    checks++; if (dct_buffer !== 30'h0) begin errors++; $display("FAIL reset_buffer got %h exp 0", dct_buffer); end
    checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", dct_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    reset_n = 1'b1;
  endtask

  task automatic test_full_word();
    out_ready = 1'b1; code = 2'd1; code_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (i == 6) begin
        checks++; if (dct_count !== 4'd7) begin errors++; $display("FAIL fill_count got %0d exp 7", dct_count); end
        checks++; if (dct_buffer !== 30'h1555) begin errors++; $display("FAIL fill_buffer got %h exp 1555", dct_buffer); end
      end
    end
    code_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== w(4'd15, 30'h15555555)) begin errors++; $display("FAIL full_word got %h exp %h", out_word, w(4'd15, 30'h15555555)); end
    checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL full_count got %0d exp 0", dct_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; code = 2'd3; code_valid = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", code_ready); end
    step();
    code_valid = 1'b0;
    checks++; if (dct_count !== 4'd1) begin errors++; $display("FAIL b2b_count got %0d exp 1", dct_count); end
    checks++; if (dct_buffer !== 30'h3) begin errors++; $display("FAIL b2b_buffer got %h exp 3", dct_buffer); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (out_word !== w(4'd1, 30'h3)) begin errors++; $display("FAIL b2b_flush got %h exp %h", out_word, w(4'd1, 30'h3)); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b1; code_valid = 1'b1;
    code = 2'd3; step();
    code = 2'd2; step();
    code = 2'd1; step();
    code_valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", out_valid); end
    checks++; if (out_word !== w(4'd3, 30'h39)) begin errors++; $display("FAIL flush_word got %h exp %h", out_word, w(4'd3, 30'h39)); end
    checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", dct_count); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; code_valid = 1'b1;
    code = 2'd2; for (int i = 0; i < 15; i++) step();
    code = 2'd3; for (int i = 0; i < 15; i++) step();
    checks++; if (dct_count !== 4'd15) begin errors++; $display("FAIL bp_count got %0d exp 15", dct_count); end
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", code_ready); end
    checks++; if (out_word !== w(4'd15, 30'h2AAAAAAA)) begin errors++; $display("FAIL bp_held got %h exp %h", out_word, w(4'd15, 30'h2AAAAAAA)); end
    code = 2'd1; step(); step();
    checks++; if (dct_buffer !== 30'h3FFFFFFF) begin errors++; $display("FAIL bp_hold_buf got %h exp 3fffffff", dct_buffer); end
    code_valid = 1'b0; out_ready = 1'b1; step();
    checks++; if (out_word !== w(4'd15, 30'h3FFFFFFF)) begin errors++; $display("FAIL bp_second got %h exp %h", out_word, w(4'd15, 30'h3FFFFFFF)); end
    checks++; if (dct_count !== 4'd0 || code_ready !== 1'b1) begin errors++; $display("FAIL bp_release got cnt %0d rdy %b exp cnt 0 rdy 1", dct_count, code_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_flush_edges();
    out_ready = 1'b1; flush = 1'b1; step(); flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush0_valid got %b exp 0", out_valid); end
    code_valid = 1'b1; code = 2'd1;
    for (int i = 0; i < 14; i++) step();
    code = 2'd2; flush = 1'b1; step(); flush = 1'b0;
    checks++; if (out_word !== w(4'd15, 30'h15555556)) begin errors++; $display("FAIL flush14_word got %h exp %h", out_word, w(4'd15, 30'h15555556)); end
    code = 2'd1; step();
    code = 2'd3; flush = 1'b1; step(); flush = 1'b0; code_valid = 1'b0;
    checks++; if (out_word !== w(4'd2, 30'h7)) begin errors++; $display("FAIL flushcode_word got %h exp %h", out_word, w(4'd2, 30'h7)); end
    step();
  endtask

  task automatic test_flush_pending();
    out_ready = 1'b0; code_valid = 1'b1; code = 2'd1;
    for (int i = 0; i < 15; i++) step();
    code = 2'd2; step(); step();
    code_valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL pend_ready got %b exp 0", code_ready); end
    checks++; if (out_word !== w(4'd15, 30'h15555555)) begin errors++; $display("FAIL pend_stable got %h exp %h", out_word, w(4'd15, 30'h15555555)); end
    code_valid = 1'b1; code = 2'd3; step(); code_valid = 1'b0;
    checks++; if (dct_count !== 4'd2) begin errors++; $display("FAIL pend_stall got %0d exp 2", dct_count); end
    out_ready = 1'b1; step();
    checks++; if (out_word !== w(4'd2, 30'hA)) begin errors++; $display("FAIL pend_word got %h exp %h", out_word, w(4'd2, 30'hA)); end
    checks++; if (dct_count !== 4'd0 || code_ready !== 1'b1) begin errors++; $display("FAIL pend_done got cnt %0d rdy %b exp cnt 0 rdy 1", dct_count, code_ready); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; code_valid = 1'b1; code = 2'd1;
    for (int i = 0; i < 22; i++) step();
    code_valid = 1'b0;
    checks++; if (dct_count !== 4'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got cnt %0d vld %b exp cnt 7 vld 1", dct_count, out_valid); end
    #2 reset_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_word !== 34'h0) begin errors++; $display("FAIL mid_out got vld %b word %h exp 0 0", out_valid, out_word); end
    checks++; if (dct_count !== 4'd0 || dct_buffer !== 30'h0 || code_ready !== 1'b1) begin errors++; $display("FAIL mid_buf got cnt %0d buf %h rdy %b exp 0 0 1", dct_count, dct_buffer, code_ready); end
    step(); reset_n = 1'b1; out_ready = 1'b1; step();
  endtask

`ifdef PROCESSOR_OCI_DCT_OVERFLOW_EN
  task automatic test_overflow();
    out_ready = 1'b0; code_valid = 1'b1;
    code = 2'd1; for (int i = 0; i < 15; i++) step();
    code = 2'd2; for (int i = 0; i < 15; i++) step();
    code = 2'd3; step(); code_valid = 1'b0;
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready got %b exp 1", code_ready); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (dct_buffer !== 30'h2AAAAAAA) begin errors++; $display("FAIL ovf_buf got %h exp 2aaaaaaa", dct_buffer); end
    flush = 1'b1; step(); flush = 1'b0;
    out_ready = 1'b1; step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    checks++; if (out_word !== w(4'd15, 30'h2AAAAAAA)) begin errors++; $display("FAIL ovf_word got %h exp %h", out_word, w(4'd15, 30'h2AAAAAAA)); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_flush_edges();
    test_flush_pending();
    test_reset_mid();
`ifdef PROCESSOR_OCI_DCT_OVERFLOW_EN
    test_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
